write_enable_sequencer: RTL and testbench

- Controller sitting upstream of the BRAM write_enable core. It turns a software start command into a one-cycle restart pulse for write_enable.
- It tracks frame boundaries on the free-running BRAM address, counts a programmed number of complete frames and flags completion.
- It supports abort. Status outputs go to the CPU register bank.

---
 rtl/write_enable_sequencer.sv | 133 +++++++++++++
 tb/tb_write_enable_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_enable_sequencer.sv
// Run controller for the BRAM write_enable core: converts a software start
// into a single restart pulse, then counts complete frames on the
// free-running BRAM address and raises a sticky done flag. All outputs are
// registered so the CPU register bank and write_enable see glitch-free values.
module write_enable_sequencer #(
  parameter int BRAM_WIDTH    = 5,
  parameter int NFRAMES_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NFRAMES_WIDTH-1:0] n_frames,
  input  logic [BRAM_WIDTH-1:0]    count_max,
  input  logic [BRAM_WIDTH-1:0]    address,
  output logic                     restart,
  output logic                     busy,
  output logic                     writing,
  output logic                     done,
  output logic [NFRAMES_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_WRAP,
    WRITE,
    DONE
  } state_t;

  state_t                   state, state_next;
  logic [NFRAMES_WIDTH-1:0] nf_l, nf_l_next;
  logic [BRAM_WIDTH-1:0]    cm_l, cm_l_next;
  logic [NFRAMES_WIDTH-1:0] frame_count_next;
  logic [NFRAMES_WIDTH-1:0] frame_count_inc;
  logic                     restart_next, busy_next, writing_next, done_next;
  logic                     boundary;

  // A frame ends on the cycle the address equals the latched last address;
  // the live count_max is deliberately not used so mid-run edits are inert.
  assign boundary        = (address == cm_l);
  assign frame_count_inc = frame_count + NFRAMES_WIDTH'(1);

  // Next-state and next-output decode; abort overrides everything, including start.
  always_comb begin
    state_next       = state;
    nf_l_next        = nf_l;
    cm_l_next        = cm_l;
    frame_count_next = frame_count;
    restart_next     = 1'b0;
    busy_next        = busy;
    writing_next     = writing;
    done_next        = done;

    if (abort) begin
      state_next   = IDLE;
      busy_next    = 1'b0;
      writing_next = 1'b0;
      done_next    = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            nf_l_next        = n_frames;
            cm_l_next        = count_max;
            frame_count_next = '0;
            writing_next     = 1'b0;
            if (n_frames == '0) begin
              state_next = DONE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end else begin
              state_next   = ARM;
              done_next    = 1'b0;
              busy_next    = 1'b1;
              restart_next = 1'b1;
            end
          end
        end
        ARM: begin
          state_next = WAIT_WRAP;
        end
        WAIT_WRAP: begin
          if (boundary) begin
            state_next   = WRITE;
            writing_next = 1'b1;
          end
        end
        WRITE: begin
          if (boundary) begin
            frame_count_next = frame_count_inc;
            if (frame_count_inc == nf_l) begin
              state_next   = DONE;
              done_next    = 1'b1;
              busy_next    = 1'b0;
              writing_next = 1'b0;
            end
          end
        end
        default: begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          writing_next = 1'b0;
          done_next    = 1'b0;
        end
      endcase
    end
  end

  // State, latched run parameters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      nf_l        <= '0;
      cm_l        <= '0;
      frame_count <= '0;
      restart     <= 1'b0;
      busy        <= 1'b0;
      writing     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      nf_l        <= nf_l_next;
      cm_l        <= cm_l_next;
      frame_count <= frame_count_next;
      restart     <= restart_next;
      busy        <= busy_next;
      writing     <= writing_next;
      done        <= done_next;
    end
  end

endmodule

// File: tb/tb_write_enable_sequencer.sv
// Directed bench for write_enable_sequencer: the bench owns a 0..15 wrapping
// address counter and checks outputs one time unit after each rising edge.
module tb_write_enable_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [15:0] n_frames;
  logic [4:0]  count_max;
  logic [4:0]  address;
  logic        restart;
  logic        busy;
  logic        writing;
  logic        done;
  logic [15:0] frame_count;

  int tests_run;
  int tests_failed;
  int restart_pulses;

  write_enable_sequencer #(
    .BRAM_WIDTH   (5),
    .NFRAMES_WIDTH(16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .n_frames   (n_frames),
    .count_max  (count_max),
    .address    (address),
    .restart    (restart),
    .busy       (busy),
    .writing    (writing),
    .done       (done),
    .frame_count(frame_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts cycles in which restart is high, to prove pulses are single and not repeated.
  always @(negedge clk) begin
    if (restart) restart_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: drive start/abort for this edge, then advance the address.
  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    @(posedge clk);
    #1;
    start   = 1'b0;
    abort   = 1'b0;
    address = (address == 5'd15) ? 5'd0 : address + 5'd1;
  endtask

  // From WAIT_WRAP: idle until the wrap address, then writing must rise.
  task automatic enterWrite();
    while (address != 5'd15) applyStimulus(1'b0, 1'b0);
    checkOutput("wait_no_writing", writing, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("writing_rise", writing, 1);
  endtask

  // In WRITE: run one full frame and check the count ticks exactly at the boundary.
  task automatic doFrame(input int expected_count);
    while (address != 5'd15) applyStimulus(1'b0, 1'b0);
    checkOutput("fc_before_boundary", frame_count, expected_count - 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("fc_after_boundary", frame_count, expected_count);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    restart_pulses = 0;
    resetn         = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    n_frames       = 16'd3;
    count_max      = 5'd15;
    address        = 5'd0;

    // Reset held with activity on the inputs.
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("rst_restart", restart, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_writing", writing, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    resetn  = 1'b1;
    address = 5'd5;
    applyStimulus(1'b0, 1'b0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_restart", restart, 0);

    // Basic three-frame run.
    applyStimulus(1'b1, 1'b0);
    checkOutput("basic_restart_hi", restart, 1);
    checkOutput("basic_busy", busy, 1);
    checkOutput("basic_writing_lo", writing, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_restart_lo", restart, 0);
    enterWrite();
    checkOutput("basic_fc0", frame_count, 0);
    doFrame(1);
    doFrame(2);
    checkOutput("basic_busy_mid", busy, 1);
    checkOutput("basic_done_mid", done, 0);
    doFrame(3);
    checkOutput("basic_done", done, 1);
    checkOutput("basic_busy_end", busy, 0);
    checkOutput("basic_writing_end", writing, 0);
    checkOutput("basic_pulses", restart_pulses, 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("basic_done_sticky", done, 1);
    checkOutput("basic_fc_hold", frame_count, 3);

    // Start from DONE, with an extra start during WRITE that must be ignored.
    while (address != 5'd0) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("ign_fc_cleared", frame_count, 0);
    checkOutput("ign_done_cleared", done, 0);
    checkOutput("ign_restart", restart, 1);
    applyStimulus(1'b0, 1'b0);
    enterWrite();
    applyStimulus(1'b1, 1'b0);
    checkOutput("ign_no_restart", restart, 0);
    checkOutput("ign_writing", writing, 1);
    doFrame(1);
    doFrame(2);
    doFrame(3);
    checkOutput("ign_done", done, 1);
    checkOutput("ign_pulses", restart_pulses, 2);

    // Abort mid-WRITE after one frame, then restart and abort in ARM.
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    enterWrite();
    doFrame(1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_writing", writing, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_fc_hold", frame_count, 1);
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("abort_idle_fc", frame_count, 1);
    checkOutput("abort_idle_busy", busy, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rearm_restart", restart, 1);
    checkOutput("rearm_fc_clear", frame_count, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("arm_abort_restart", restart, 0);
    checkOutput("arm_abort_busy", busy, 0);
    repeat (20) applyStimulus(1'b0, 1'b0);
    checkOutput("arm_abort_writing", writing, 0);
    checkOutput("abort_pulses", restart_pulses, 4);

    // Zero-frame request and start colliding with abort.
    n_frames = 16'd0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_restart", restart, 0);
    checkOutput("zero_fc", frame_count, 0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("zero_abort_done", done, 0);
    n_frames = 16'd2;
    applyStimulus(1'b1, 1'b1);
    checkOutput("collide_restart", restart, 0);
    checkOutput("collide_busy", busy, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("collide_restart2", restart, 0);
    checkOutput("collide_pulses", restart_pulses, 4);

    // Latched parameters: edits during WAIT_WRAP must not move the boundary or frame total.
    while (address != 5'd0) applyStimulus(1'b0, 1'b0);
    n_frames  = 16'd1;
    count_max = 5'd15;
    applyStimulus(1'b1, 1'b0);
    count_max = 5'd7;
    n_frames  = 16'd5;
    applyStimulus(1'b0, 1'b0);
    while (address != 5'd8) applyStimulus(1'b0, 1'b0);
    checkOutput("latch_no_write_at7", writing, 0);
    enterWrite();
    doFrame(1);
    checkOutput("latch_done", done, 1);
    checkOutput("latch_busy", busy, 0);

    // Asynchronous reset in the middle of a run.
    n_frames  = 16'd2;
    count_max = 5'd15;
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_pre_restart", restart, 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_restart", restart, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_fc", frame_count, 0);
    applyStimulus(1'b0, 1'b0);
    resetn = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkOutput("postrst_restart", restart, 0);
    checkOutput("postrst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
